// File: rtl/pixel_pkg.sv
// pixel_pkg: pixel width, lane count, packer state type and line geometry helper.
package pixel_pkg;
  localparam int PIX_W = 24;
  localparam int LANES = 8;
  typedef enum logic [1:0] {IDLE, PACK, PAD} pack_state_t;
  function automatic int beats_per_line(input int m);
    return m / LANES;
  endfunction
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: groups framed pixels into 8-lane beats, exactly M/8 beats per line.
// Define PIXEL_PACKER_PAD_EN to pad early-EOL lines with the last pixel instead of aborting them.
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int N = PIX_W,
  parameter int M = 240
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_pixel,
  input  logic         i_valid,
  input  logic         i_sol,
  input  logic         i_eol,
  output logic         o_ready,
  output logic [N-1:0] o_data1,
  output logic [N-1:0] o_data2,
  output logic [N-1:0] o_data3,
  output logic [N-1:0] o_data4,
  output logic [N-1:0] o_data5,
  output logic [N-1:0] o_data6,
  output logic [N-1:0] o_data7,
  output logic [N-1:0] o_data8,
  output logic         o_write,
  output logic         o_line_done,
  output logic         o_err
);
  localparam int BEATS = beats_per_line(M);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  pack_state_t state_q, state_d;
  logic [2:0] lane_q, lane_d, base_lane;
  logic [BW-1:0] beat_q, beat_d, base_beat;
  logic [N-1:0] lanes_q [LANES];
  logic [N-1:0] lanes_d [LANES];
  logic [N-1:0] data_q [LANES];
  logic [N-1:0] data_d [LANES];
  logic write_q, write_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic take, full, last, early;
`ifdef PIXEL_PACKER_PAD_EN
  logic [N-1:0] hold_q, hold_d;
`endif
  // SOL always restarts framing, so it overrides the running lane/beat position
  always_comb begin
    take = i_valid && ready_q && (i_sol || state_q == PACK);
    base_lane = i_sol ? 3'd0 : lane_q;
    base_beat = i_sol ? '0 : beat_q;
    full = base_lane == 3'd7;
    last = full && base_beat == LAST_BEAT;
    early = i_eol && !last;
  end
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    beat_d = beat_q;
    lanes_d = lanes_q;
    data_d = data_q;
    write_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    ready_d = 1'b1;
`ifdef PIXEL_PACKER_PAD_EN
    hold_d = hold_q;
`endif
    if (take) begin
      lanes_d[base_lane] = i_pixel;
      lane_d = base_lane + 3'd1;
      beat_d = full ? (last ? '0 : base_beat + 1'b1) : base_beat;
      err_d = i_sol && state_q == PACK;
      state_d = last ? IDLE : PACK;
      if (full) begin
        data_d = lanes_d;
        write_d = 1'b1;
        done_d = last;
      end
`ifdef PIXEL_PACKER_PAD_EN
      hold_d = i_pixel;
      if (early) begin
        state_d = PAD;
        ready_d = 1'b0;
      end
`else
      if (early) begin
        state_d = IDLE;
        lane_d = 3'd0;
        beat_d = '0;
        err_d = 1'b1;
      end
`endif
    end
`ifdef PIXEL_PACKER_PAD_EN
    // lanes below lane_q already hold real pixels of the open beat; the rest replicate
    else if (state_q == PAD) begin
      for (int i = 0; i < LANES; i++) data_d[i] = (3'(i) < lane_q) ? lanes_q[i] : hold_q;
      write_d = 1'b1;
      done_d = beat_q == LAST_BEAT;
      lane_d = 3'd0;
      beat_d = done_d ? '0 : beat_q + 1'b1;
      state_d = done_d ? IDLE : PAD;
      ready_d = done_d;
    end
`endif
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      lane_q <= 3'd0;
      beat_q <= '0;
      lanes_q <= '{default: '0};
      data_q <= '{default: '0};
      write_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef PIXEL_PACKER_PAD_EN
      hold_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      beat_q <= beat_d;
      lanes_q <= lanes_d;
      data_q <= data_d;
      write_q <= write_d;
      done_q <= done_d;
      err_q <= err_d;
      ready_q <= ready_d;
`ifdef PIXEL_PACKER_PAD_EN
      hold_q <= hold_d;
`endif
    end
  end
  assign o_ready = ready_q;
  assign o_write = write_q;
  assign o_line_done = done_q;
  assign o_err = err_q;
  assign o_data1 = data_q[0];
  assign o_data2 = data_q[1];
  assign o_data3 = data_q[2];
  assign o_data4 = data_q[3];
  assign o_data5 = data_q[4];
  assign o_data6 = data_q[5];
  assign o_data7 = data_q[6];
  assign o_data8 = data_q[7];
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: line-level model of pixel_packer with a per-cycle compare process and directed scenarios.
module tb_pixel_packer;
  localparam int M = 240;
  typedef struct packed {
    logic ld;
    logic [7:0][23:0] px;
  } beat_t;
  logic i_clk = 1'b0, i_rst = 1'b0, i_valid = 1'b0, i_sol = 1'b0, i_eol = 1'b0;
  logic [23:0] i_pixel = '0;
  logic o_ready, o_write, o_line_done, o_err;
  logic [23:0] o_data1, o_data2, o_data3, o_data4, o_data5, o_data6, o_data7, o_data8;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  beat_t exp_q[$];
  logic [23:0] line_px[$];
  bit in_line = 0, err_exp = 0;
  int wr_cyc[$];
  logic [23:0] wr_d1[$], wr_d4[$], wr_d5[$], wr_d8[$];
  bit wr_ld[$];
  int errs_seen = 0, rdy_low = 0;

  pixel_packer #(.N(24), .M(M)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pixel(i_pixel), .i_valid(i_valid), .i_sol(i_sol), .i_eol(i_eol),
    .o_ready(o_ready), .o_data1(o_data1), .o_data2(o_data2), .o_data3(o_data3), .o_data4(o_data4),
    .o_data5(o_data5), .o_data6(o_data6), .o_data7(o_data7), .o_data8(o_data8),
    .o_write(o_write), .o_line_done(o_line_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input bit ld);
    beat_t b;
    int n = line_px.size();
    for (int i = 0; i < 8; i++) b.px[i] = line_px[n-8+i];
    b.ld = ld;
    exp_q.push_back(b);
  endtask

  // line-level rules: SOL opens a line, a line is M pixels, EOL before that is early
  task automatic model_accept(input logic [23:0] p, input bit s, input bit e);
    if (s) begin
      if (in_line) err_exp = 1;
      line_px.delete();
      in_line = 1;
    end
    if (!in_line) return;
    line_px.push_back(p);
    if (line_px.size() % 8 == 0) push_beat(line_px.size() == M);
    if (line_px.size() == M) begin
      in_line = 0;
      line_px.delete();
    end else if (e) begin
`ifdef PIXEL_PACKER_PAD_EN
      while (line_px.size() < M) begin
        line_px.push_back(p);
        if (line_px.size() % 8 == 0) push_beat(line_px.size() == M);
      end
`else
      err_exp = 1;
`endif
      in_line = 0;
      line_px.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    line_px.delete();
    in_line = 0;
    err_exp = 0;
  endtask

  always @(negedge i_clk) begin
    beat_t b;
    if (!i_rst) begin
      chk("err", o_err, err_exp);
      err_exp = 0;
      if (o_err) errs_seen++;
      if (!o_ready) rdy_low++;
      if (o_write) begin
        wr_cyc.push_back(cyc);
        wr_d1.push_back(o_data1);
        wr_d4.push_back(o_data4);
        wr_d5.push_back(o_data5);
        wr_d8.push_back(o_data8);
        wr_ld.push_back(o_line_done);
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          b = exp_q.pop_front();
          chk("data1", o_data1, b.px[0]);
          chk("data2", o_data2, b.px[1]);
          chk("data3", o_data3, b.px[2]);
          chk("data4", o_data4, b.px[3]);
          chk("data5", o_data5, b.px[4]);
          chk("data6", o_data6, b.px[5]);
          chk("data7", o_data7, b.px[6]);
          chk("data8", o_data8, b.px[7]);
          chk("line_done", o_line_done, b.ld);
        end
      end else chk("line_done_no_write", o_line_done, 0);
    end
  end

  task automatic send(input logic [23:0] p, input bit s, input bit e);
    bit acc, done = 0;
    int k = 0;
    i_pixel = p;
    i_valid = 1;
    i_sol = s;
    i_eol = e;
    while (!done && k < 100) begin
      acc = o_ready;
      @(posedge i_clk);
      if (acc) begin
        model_accept(p, s, e);
        done = 1;
      end
      @(negedge i_clk);
      k++;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_line(input int base);
    for (int k = 0; k < M; k++) send(24'(base + k), k == 0, k == M - 1);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_d1.delete();
    wr_d4.delete();
    wr_d5.delete();
    wr_d8.delete();
    wr_ld.delete();
    errs_seen = 0;
    rdy_low = 0;
  endtask

  task automatic drain();
    i_valid = 0;
    i_sol = 0;
    i_eol = 0;
    repeat (40) @(negedge i_clk);
    chk("leftover_beats", exp_q.size(), 0);
  endtask

  task automatic chk_clean_line(input string nm, input int base);
    chk({nm, "_writes"}, wr_cyc.size(), 30);
    chk({nm, "_first_d1"}, wr_d1[0], 24'(base));
    chk({nm, "_first_d8"}, wr_d8[0], 24'(base + 7));
    chk({nm, "_last_d1"}, wr_d1[29], 24'(base + 232));
    chk({nm, "_last_d8"}, wr_d8[29], 24'(base + 239));
    chk({nm, "_span"}, wr_cyc[29] - wr_cyc[0], 232);
    chk({nm, "_ld_last"}, wr_ld[29], 1);
    chk({nm, "_ld_first"}, wr_ld[0], 0);
    chk({nm, "_errs"}, errs_seen, 0);
  endtask

  initial begin
    #2 i_rst = 1;
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_write", o_write, 0);
    chk("rst_d1", o_data1, 0);
    chk("rst_d8", o_data8, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ld", o_line_done, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    chk("ready_before_edge", o_ready, 0);
    @(negedge i_clk);
    chk("ready_after_edge", o_ready, 1);

    clear_log();
    send_line(0);
    drain();
    chk_clean_line("s1", 0);
    chk("s1_ready_low", rdy_low, 0);

    clear_log();
    for (int k = 0; k < 5; k++) send(24'(500 + k), 0, 0);
    send_line(0);
    drain();
    chk_clean_line("s2", 0);

    clear_log();
    for (int k = 0; k < 13; k++) send(24'(k), k == 0, 0);
    send_line(1000);
    drain();
    chk("s3_errs", errs_seen, 1);
    chk("s3_writes", wr_cyc.size(), 31);
    chk("s3_restart_d1", wr_d1[1], 1000);
    chk("s3_last_d8", wr_d8[30], 1239);
    chk("s3_ld", wr_ld[30], 1);

    clear_log();
    for (int k = 0; k <= 100; k++) send(k == 100 ? 24'hABCDEF : 24'(k), k == 0, k == 100);
    drain();
`ifdef PIXEL_PACKER_PAD_EN
    chk("s4_writes", wr_cyc.size(), 30);
    chk("s4_b12_d4", wr_d4[12], 99);
    chk("s4_b12_d5", wr_d5[12], 24'hABCDEF);
    chk("s4_b12_d8", wr_d8[12], 24'hABCDEF);
    chk("s4_b29_d1", wr_d1[29], 24'hABCDEF);
    chk("s4_pad_span", wr_cyc[29] - wr_cyc[12], 17);
    chk("s4_ld", wr_ld[29], 1);
    chk("s4_ready_low", rdy_low, 18);
    chk("s4_errs", errs_seen, 0);
`else
    chk("s4_writes", wr_cyc.size(), 12);
    chk("s4_errs", errs_seen, 1);
    chk("s4_ready_low", rdy_low, 0);
`endif

    clear_log();
    for (int k = 0; k <= 50; k++) send(24'(k), k == 0, 0);
    #1 i_rst = 1;
    #1;
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_d1", o_data1, 0);
    chk("mid_rst_write", o_write, 0);
    model_reset();
    i_valid = 0;
    i_sol = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    @(negedge i_clk);
    chk("mid_rst_ready_back", o_ready, 1);
    clear_log();
    send_line(2000);
    drain();
    chk_clean_line("s5", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
